// File: rtl/regfile_sb.sv
// Register file with NUM_RD registered read ports, ALU and load-return write ports, and a load scoreboard.
// Optional write-first read bypass: define REGFILE_BYPASS_EN (default build is read-first).
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     Clock,
   input  logic                     Reset_L,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     ld_wr_en_i,
   input  logic [ADDR_W-1:0]        ld_wr_addr_i,
   input  logic [DATA_W-1:0]        ld_wr_data_i,
   input  logic                     ld_issue_i,
   input  logic [ADDR_W-1:0]        ld_issue_addr_i,
   input  logic                     conflict_clr_i,
   output logic [ADDR_W:0]          busy_cnt_o,
   output logic                     conflict_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0]        regs_q [DEPTH];
   logic [DEPTH-1:0]         busy_q, busy_d;
   logic [CNT_W-1:0]         busy_cnt_q, busy_cnt_d;
   logic                     conflict_q, conflict_d;
   logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;

   logic w_en, l_en, iss_en, collide, iss_meets_ret, cnt_inc, cnt_dec, conflict_set;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Address 0 is filtered out of every operation up front when hardwired to zero.
   assign w_en   = wr_en_i    && !is_zero(wr_addr_i);
   assign l_en   = ld_wr_en_i && !is_zero(ld_wr_addr_i);
   assign iss_en = ld_issue_i && !is_zero(ld_issue_addr_i);

   assign collide       = w_en && l_en && (wr_addr_i == ld_wr_addr_i);
   assign iss_meets_ret = iss_en && l_en && (ld_issue_addr_i == ld_wr_addr_i);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      busy_d = busy_q;
      if (l_en)   busy_d[ld_wr_addr_i]    = 1'b0;
      if (iss_en) busy_d[ld_issue_addr_i] = 1'b1;
   end

   // A same-cycle return to the issuing address leaves the bit set, so neither count edge fires.
   assign cnt_inc    = iss_en && !busy_q[ld_issue_addr_i];
   assign cnt_dec    = l_en && busy_q[ld_wr_addr_i] && !iss_meets_ret;
   assign busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

   assign conflict_set = (iss_en && busy_q[ld_issue_addr_i] && !iss_meets_ret)
                       || (w_en && busy_q[wr_addr_i])
                       || collide
                       || (l_en && !busy_q[ld_wr_addr_i]);
   assign conflict_d   = conflict_set || (conflict_q && !conflict_clr_i);

   always_comb begin
      rd_data_d = '0;
      rd_busy_o = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         logic [ADDR_W-1:0] a;
         a = rd_addr_i[p*ADDR_W +: ADDR_W];
         rd_busy_o[p] = busy_q[a];
         rd_data_d[p*DATA_W +: DATA_W] = regs_q[a];
`ifdef REGFILE_BYPASS_EN
         if (w_en && (wr_addr_i == a))
            rd_data_d[p*DATA_W +: DATA_W] = wr_data_i;
         else if (l_en && (ld_wr_addr_i == a))
            rd_data_d[p*DATA_W +: DATA_W] = ld_wr_data_i;
`endif
         if (is_zero(a)) rd_data_d[p*DATA_W +: DATA_W] = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         // NOTE: the array is reset because architectural state must read 0 after reset.
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         busy_q     <= '0;
         busy_cnt_q <= '0;
         conflict_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         if (l_en && !collide) regs_q[ld_wr_addr_i] <= ld_wr_data_i;
         if (w_en)             regs_q[wr_addr_i]    <= wr_data_i;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
         conflict_q <= conflict_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign busy_cnt_o = busy_cnt_q;
   assign conflict_o = conflict_q;

endmodule
